// File: rtl/ray_sched_pkg.sv
// Shared constants for the ray/triangle scheduler: FSM encodings, the "no hit"
// distance and the layout of the six ray components packed into ray_in.
package ray_sched_pkg;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE  = 2'd0;
  localparam sched_state_t ST_ISSUE = 2'd1;
  localparam sched_state_t ST_DRAIN = 2'd2;
  localparam sched_state_t ST_DONE  = 2'd3;

  localparam int          T_NONE_W = 32;
  localparam logic [31:0] T_NONE   = '1;

  // Component slots within ray_in; bit offset of a slot is slot*WIDTH.
  localparam int RAY_P1     = 0;
  localparam int RAY_P2     = 1;
  localparam int RAY_P3     = 2;
  localparam int RAY_D1     = 3;
  localparam int RAY_D2     = 4;
  localparam int RAY_D3     = 5;
  localparam int RAY_FIELDS = 6;

  function automatic int ray_lsb(input int slot, input int width);
    return slot * width;
  endfunction

endpackage

// File: rtl/tag_delay.sv
// Delay line of {valid, index} tags that follows each triangle read through
// memory and the intersection datapath so results can be matched to indices.
module tag_delay #(
  parameter int IDX_W = 10,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             pending
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign out_valid = in_valid;
      assign out_idx   = in_idx;
      assign pending   = 1'b0;
    end else begin : g_pipe
      logic [DEPTH-1:0] v_q, v_d;
      logic [IDX_W-1:0] idx_q [DEPTH];
      logic [IDX_W-1:0] idx_d [DEPTH];

      // pending ignores the output stage: it says whether any tag is still
      // due after the one being consumed this cycle.
      always_comb begin
        v_d[0]   = in_valid;
        idx_d[0] = in_idx;
        for (int i = 1; i < DEPTH; i++) begin
          v_d[i]   = v_q[i-1];
          idx_d[i] = idx_q[i-1];
        end
        pending = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
          pending = pending | v_q[i];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= '0;
          for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
        end else begin
          v_q   <= v_d;
          idx_q <= idx_d;
        end
      end

      assign out_valid = v_q[DEPTH-1];
      assign out_idx   = idx_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/ray_tri_scheduler.sv
// Streams one ray against tri_count triangles through a shared intersection
// datapath and returns the nearest hit.
module ray_tri_scheduler
  import ray_sched_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int IDX_W   = 10,
  parameter int LAT     = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ray_valid,
  output logic                        ray_ready,
  input  logic [RAY_FIELDS*WIDTH-1:0] ray_in,
  input  logic [IDX_W:0]              tri_count,
  output logic [RAY_FIELDS*WIDTH-1:0] ray_out,
  output logic                        tri_rd_en,
  output logic [IDX_W-1:0]            tri_addr,
  input  logic                        hit_flag,
  input  logic [WIDTH-1:0]            hit_t,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        res_hit,
  output logic [IDX_W-1:0]            res_idx,
  output logic [WIDTH-1:0]            res_t,
  output logic                        busy,
  output logic [1:0]                  dbg_state
);

  localparam int               DEPTH   = MEM_LAT + LAT;
  localparam int               RAY_W   = RAY_FIELDS * WIDTH;
  localparam logic [WIDTH-1:0] T_ALL   = '1;
  localparam logic [IDX_W-1:0] ONE_IDX = 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the offering side holds its payload until that edge.

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [RAY_W-1:0]   ray_q, ray_d;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   t_q, t_d;
  logic [IDX_W:0]     cnt_clamp;
  logic               tag_valid;
  logic [IDX_W-1:0]   tag_idx;
  logic               tag_pending;

  tag_delay #(.IDX_W(IDX_W), .DEPTH(DEPTH)) u_tag_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (tri_rd_en),
    .in_idx    (tri_addr),
    .out_valid (tag_valid),
    .out_idx   (tag_idx),
    .pending   (tag_pending)
  );

  always_comb begin
    cnt_clamp = tri_count;
    if (tri_count[IDX_W] && (|tri_count[IDX_W-1:0])) begin
      cnt_clamp = {1'b1, {IDX_W{1'b0}}};
    end

    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    ray_d   = ray_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
    t_d     = t_q;

    // Strict compare keeps the lower index on ties and rejects t == all ones.
    if (tag_valid && hit_flag && (hit_t < t_q)) begin
      hit_d = 1'b1;
      idx_d = tag_idx;
      t_d   = hit_t;
    end

    case (state_q)
      ST_IDLE: begin
        if (ray_valid) begin
          ray_d   = ray_in;
          last_d  = cnt_clamp[IDX_W-1:0] - ONE_IDX;
          addr_d  = '0;
          hit_d   = 1'b0;
          idx_d   = '0;
          t_d     = T_ALL;
          state_d = (tri_count == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (addr_q == last_q) begin
          addr_d  = '0;
          state_d = (DEPTH == 0) ? ST_DONE : ST_DRAIN;
        end else begin
          addr_d = addr_q + ONE_IDX;
        end
      end
      ST_DRAIN: begin
        if (!tag_pending) state_d = ST_DONE;
      end
      default: begin
        if (res_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      ray_q   <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
      t_q     <= T_ALL;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      ray_q   <= ray_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
      t_q     <= t_d;
    end
  end

  assign ray_ready = (state_q == ST_IDLE);
  assign tri_rd_en = (state_q == ST_ISSUE);
  assign tri_addr  = addr_q;
  assign res_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign ray_out   = ray_q;
  assign res_hit   = hit_q;
  assign res_idx   = idx_q;
  assign res_t     = t_q;
  assign dbg_state = state_q;

endmodule

// File: doc/ray_tri_scheduler.md
Name: ray_tri_scheduler

Overview:
- Sequences one ray against a list of triangles through a single shared ray/triangle intersection datapath (pipelined, fixed latency LAT).
- Accepts a ray over a valid/ready handshake and issues one triangle read per cycle to triangle memory; memory data feeds the intersection datapath directly.
- Tracks the nearest valid hit and returns hit flag, triangle index and t over a valid/ready handshake.
- Sits between the ray generator and the shading stage.

Parameters:
- WIDTH, 32, width of one vector component and of t (unsigned)
- IDX_W, 10, triangle index width; up to 2^IDX_W triangles
- LAT, 4, cycles from triangle data presented to intersection datapath until hit_flag/hit_t valid; 0 legal (combinational)
- MEM_LAT, 1, triangle memory read latency in cycles (fixed, no backpressure)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ray_valid  in  1  ray offered
- ray_ready  out  1  scheduler can accept a ray
- ray_in  in  6*WIDTH  {p1,p2,p3,d1,d2,d3}, p1 in LSBs
- tri_count  in  IDX_W+1  triangles to test, sampled on ray accept
- ray_out  out  6*WIDTH  latched ray driven to datapath, stable while busy
- tri_rd_en  out  1  triangle memory read strobe
- tri_addr  out  IDX_W  triangle index being read
- hit_flag  in  1  datapath valid-intersection flag for the aligned triangle
- hit_t  in  WIDTH  datapath intersection distance (unsigned)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_hit  out  1  at least one triangle hit
- res_idx  out  IDX_W  index of nearest hit (0 if none)
- res_t  out  WIDTH  nearest t (all ones if none)
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, ray_ready=1, tri_rd_en=0, tri_addr=0, res_valid=0, res_hit=0, res_idx=0, res_t=all ones, ray_out=0, tag pipe cleared, busy=0.
- Reset mid-operation: all in-flight tags discarded; no result is produced for the aborted ray.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: ray_ready=1. On ray_valid&ray_ready, latch ray_in->ray_out and tri_count; clear best (res_hit=0, res_t=all ones, res_idx=0); go to ISSUE, or to DONE if tri_count==0.
- ISSUE: tri_rd_en=1, tri_addr counts 0..tri_count-1, one per cycle, with no gaps. On the cycle addr==tri_count-1, go to DRAIN.
- Tag pipe: a depth MEM_LAT+LAT delay line of {valid, index}, pushed with {tri_rd_en, tri_addr}.
- Tag output valid means hit_flag/hit_t belong to the tagged index this cycle.
- If hit_flag and hit_t < res_t (strict unsigned compare), update res_hit=1, res_t=hit_t, res_idx=tag index.
- Ties keep the earlier (lower) index.
- A t of all ones that hits still sets res_hit only if strictly less than all ones; such a hit is therefore treated as a miss.
- DRAIN: tri_rd_en=0. When the tag pipe holds no valid entry (the last tag was consumed the previous cycle), go to DONE.
- DONE: res_valid=1; res_* held stable until res_valid&res_ready, then go to IDLE. ray_ready=0 here; no new ray is accepted in the same cycle as result handoff.
- Latency: accept at cycle 0, N=tri_count.
  - Issues occur on cycles 1..N.
  - The last result is sampled at N+MEM_LAT+LAT.
  - res_valid rises at cycle N+MEM_LAT+LAT+1.
  - For N=0, res_valid rises at cycle 1.
- ray_ready=0 in ISSUE/DRAIN/DONE. ray_in changes while busy are ignored.
- tri_count > 2^IDX_W is clamped to 2^IDX_W.

Decomposition:
- Package ray_sched_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), T_NONE constant (all ones of WIDTH), ray field offsets within ray_in.
- Sub-module tag_delay: parameterised {valid, IDX_W} shift register of depth MEM_LAT+LAT with synchronous clear; depth 0 is a wire.
- Top contains the FSM, address counter and nearest-hit compare/update.

Test Plan:
- tri_count=0, ray accepted at cycle 0 -> res_valid at cycle 1, res_hit=0, res_idx=0, res_t=FFFFFFFF; tri_rd_en never asserts.
- tri_count=3, MEM_LAT=1, LAT=4, model hits only idx1 with t=50 -> tri_addr 0,1,2 on cycles 1-3; res_valid at cycle 9 with res_hit=1, res_idx=1, res_t=50.
- tri_count=4, hits t={80,30,30,90} at idx 0..3 -> res_idx=1, res_t=30 (tie keeps lower index).
- res_ready held low 5 cycles after res_valid -> res_* stable, ray_ready=0 and a second offered ray is not accepted. Raise res_ready -> IDLE next cycle; ray accepted the cycle after.
- rst pulsed on cycle 2 of a tri_count=5 ray with idx0 a hit -> next cycle all outputs at reset values. Late tags must not update res_*. A new ray with no hits returns res_hit=0.
- LAT=0, MEM_LAT=1, tri_count=2, hits at both with t=7,7 -> res_valid at cycle 4, res_idx=0, res_t=7.
